// File: rtl/coin_credit_accumulator.sv
// coin_credit_accumulator
//
// Front end of the vending controller. It accepts coin events, keeps the
// running credit shown to the vending FSM as total_coins, rejects coins that
// would exceed MAX_CREDIT, and clears credit when a sale completes. On user
// cancel or inactivity timeout it holds the credit in a refund handshake
// until the payout mechanism acknowledges it.
//
// Ports
//   clk            in   rising-edge clock
//   reset          in   synchronous, active-low reset
//   session_start  in   opens a credit session (IDLE -> COLLECT)
//   coin_valid     in   one-cycle coin event
//   coin_type      in   [1:0] denomination, qualified by coin_valid
//   txn_done       in   sale completed, credit cleared
//   txn_cancel     in   user cancel, starts a refund
//   refund_ack     in   payout mechanism has taken the refund
//   total_coins    out  [6:0] accepted credit
//   coin_accept    out  one-cycle pulse, coin credited
//   coin_reject    out  one-cycle pulse, coin returned to the user
//   refund_valid   out  refund pending
//   refund_amount  out  [6:0] refund value, stable while refund_valid
//   busy           out  high in any state other than IDLE
//
// All outputs are registered.

module coin_credit_accumulator #(
  parameter logic [6:0]  VAL_C0         = 7'd5,
  parameter logic [6:0]  VAL_C1         = 7'd10,
  parameter logic [6:0]  VAL_C2         = 7'd20,
  parameter logic [6:0]  VAL_C3         = 7'd50,
  parameter logic [6:0]  MAX_CREDIT     = 7'd100,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       session_start,
  input  logic       coin_valid,
  input  logic [1:0] coin_type,
  input  logic       txn_done,
  input  logic       txn_cancel,
  input  logic       refund_ack,
  output logic [6:0] total_coins,
  output logic       coin_accept,
  output logic       coin_reject,
  output logic       refund_valid,
  output logic [6:0] refund_amount,
  output logic       busy
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_REFUND  = 2'd2;

  logic [1:0]  state_q,         state_d;
  logic [6:0]  total_q,         total_d;
  logic [15:0] timer_q,         timer_d;
  logic        accept_q,        accept_d;
  logic        reject_q,        reject_d;
  logic        refund_valid_q,  refund_valid_d;
  logic [6:0]  refund_amount_q, refund_amount_d;
  logic        busy_q,          busy_d;
  logic [7:0]  sum;
  logic        timeout;

  function automatic logic [6:0] coin_value(input logic [1:0] t);
    case (t)
      2'b00:   coin_value = VAL_C0;
      2'b01:   coin_value = VAL_C1;
      2'b10:   coin_value = VAL_C2;
      default: coin_value = VAL_C3;
    endcase
  endfunction

  // One bit wider than the credit so an overflowing coin is never aliased
  // back into range.
  assign sum     = {1'b0, total_q} + {1'b0, coin_value(coin_type)};
  assign timeout = (timer_q == TIMEOUT_CYCLES - 16'd1);

  always_comb begin
    state_d         = state_q;
    total_d         = total_q;
    timer_d         = timer_q;
    accept_d        = 1'b0;
    reject_d        = 1'b0;
    refund_valid_d  = refund_valid_q;
    refund_amount_d = refund_amount_q;

    case (state_q)
      ST_IDLE: begin
        total_d         = 7'd0;
        refund_valid_d  = 1'b0;
        refund_amount_d = 7'd0;
        reject_d        = coin_valid;
        if (session_start) begin
          state_d = ST_COLLECT;
          timer_d = 16'd0;
        end
      end

      ST_COLLECT: begin
        // A coin coinciding with done/cancel/timeout is never credited.
        if (txn_done) begin
          total_d  = 7'd0;
          state_d  = ST_IDLE;
          reject_d = coin_valid;
        end else if (txn_cancel || timeout) begin
          state_d         = ST_REFUND;
          refund_valid_d  = 1'b1;
          refund_amount_d = total_q;
          reject_d        = coin_valid;
        end else if (coin_valid) begin
          if (sum <= {1'b0, MAX_CREDIT}) begin
            total_d  = sum[6:0];
            accept_d = 1'b1;
            timer_d  = 16'd0;
          end else begin
            // Rejected coin does not count as activity nor as idle time.
            reject_d = 1'b1;
          end
        end else if (timer_q != 16'hFFFF) begin
          timer_d = timer_q + 16'd1;
        end
      end

      ST_REFUND: begin
        refund_valid_d = 1'b1;
        reject_d       = coin_valid;
        if (refund_ack) begin
          total_d         = 7'd0;
          refund_valid_d  = 1'b0;
          refund_amount_d = 7'd0;
          state_d         = ST_IDLE;
        end
      end

      default: begin
        state_d         = ST_IDLE;
        total_d         = 7'd0;
        timer_d         = 16'd0;
        refund_valid_d  = 1'b0;
        refund_amount_d = 7'd0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q         <= ST_IDLE;
      total_q         <= 7'd0;
      timer_q         <= 16'd0;
      accept_q        <= 1'b0;
      reject_q        <= 1'b0;
      refund_valid_q  <= 1'b0;
      refund_amount_q <= 7'd0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      total_q         <= total_d;
      timer_q         <= timer_d;
      accept_q        <= accept_d;
      reject_q        <= reject_d;
      refund_valid_q  <= refund_valid_d;
      refund_amount_q <= refund_amount_d;
      busy_q          <= busy_d;
    end
  end

  assign total_coins   = total_q;
  assign coin_accept   = accept_q;
  assign coin_reject   = reject_q;
  assign refund_valid  = refund_valid_q;
  assign refund_amount = refund_amount_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_coin_credit_accumulator.sv
// Self-checking bench for coin_credit_accumulator: directed scenarios
// followed by randomized traffic, all checked cycle by cycle against a
// transaction-level reference model of the credit session.

module tb_coin_credit_accumulator;

  localparam int TMO = 8;
  localparam int MAXC = 100;

  logic       clk = 1'b0;
  logic       reset;
  logic       session_start;
  logic       coin_valid;
  logic [1:0] coin_type;
  logic       txn_done;
  logic       txn_cancel;
  logic       refund_ack;
  logic [6:0] total_coins;
  logic       coin_accept;
  logic       coin_reject;
  logic       refund_valid;
  logic [6:0] refund_amount;
  logic       busy;

  coin_credit_accumulator #(
    .TIMEOUT_CYCLES(16'(TMO))
  ) dut (
    .clk(clk),
    .reset(reset),
    .session_start(session_start),
    .coin_valid(coin_valid),
    .coin_type(coin_type),
    .txn_done(txn_done),
    .txn_cancel(txn_cancel),
    .refund_ack(refund_ack),
    .total_coins(total_coins),
    .coin_accept(coin_accept),
    .coin_reject(coin_reject),
    .refund_valid(refund_valid),
    .refund_amount(refund_amount),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: a session is either closed, collecting credit, or
  // waiting for a refund to be collected. idle_edges counts edges spent
  // collecting since the last credit activity.
  typedef enum int {M_CLOSED, M_OPEN, M_PAYBACK} mphase_t;
  mphase_t m_phase = M_CLOSED;
  int m_credit = 0, m_idle_edges = 0, m_refund = 0;
  int e_acc = 0, e_rej = 0;

  function automatic int denom(input logic [1:0] t);
    int vals[4] = '{5, 10, 20, 50};
    return vals[t];
  endfunction

  task automatic model_edge();
    e_acc = 0;
    e_rej = 0;
    if (!reset) begin
      m_phase = M_CLOSED; m_credit = 0; m_refund = 0; m_idle_edges = 0;
      return;
    end
    case (m_phase)
      M_CLOSED: begin
        m_credit = 0;
        if (coin_valid) e_rej = 1;
        if (session_start) begin m_phase = M_OPEN; m_idle_edges = 0; end
      end
      M_OPEN: begin
        if (txn_done) begin
          m_credit = 0; m_phase = M_CLOSED; e_rej = coin_valid;
        end else if (txn_cancel || (m_idle_edges + 1 == TMO)) begin
          m_refund = m_credit; m_phase = M_PAYBACK; e_rej = coin_valid;
        end else if (coin_valid) begin
          if (m_credit + denom(coin_type) <= MAXC) begin
            m_credit += denom(coin_type); e_acc = 1; m_idle_edges = 0;
          end else e_rej = 1;
        end else m_idle_edges++;
      end
      default: begin
        e_rej = coin_valid;
        if (refund_ack) begin
          m_credit = 0; m_refund = 0; m_phase = M_CLOSED;
        end
      end
    endcase
  endtask

  // Apply the current inputs across one rising edge, then compare outputs.
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_val("total",   total_coins,   m_credit);
    check_val("accept",  coin_accept,   e_acc);
    check_val("reject",  coin_reject,   e_rej);
    check_val("rvalid",  refund_valid,  m_phase == M_PAYBACK);
    check_val("ramount", refund_amount, m_refund);
    check_val("busy",    busy,          m_phase != M_CLOSED);
  endtask

  task automatic quiet();
    session_start = 0; coin_valid = 0; coin_type = 0;
    txn_done = 0; txn_cancel = 0; refund_ack = 0;
  endtask

  task automatic coin(input logic [1:0] t);
    quiet(); coin_valid = 1; coin_type = t; step();
  endtask

  initial begin
    reset = 1'b0;
    quiet();
    // Reset with coins applied: no pulses, everything zero.
    coin_valid = 1; coin_type = 2'b11;
    step(); step();
    check_val("rst_accept", coin_accept, 0);
    check_val("rst_reject", coin_reject, 0);
    reset = 1'b1;

    // Coin in IDLE is returned.
    coin(2'b10);
    check_val("idle_reject", coin_reject, 1);
    check_val("idle_total", total_coins, 0);

    // Session, 20 + 50 + 10 back to back.
    quiet(); session_start = 1; step();
    coin(2'b10); check_val("t20", total_coins, 20);
    coin(2'b11); check_val("t70", total_coins, 70);
    coin(2'b01); check_val("t80", total_coins, 80);
    // Over-limit then exact limit.
    coin(2'b11); check_val("over_rej", coin_reject, 1);
    check_val("over_total", total_coins, 80);
    coin(2'b10); check_val("at_max", total_coins, 100);
    quiet(); txn_done = 1; step();
    check_val("done_total", total_coins, 0);
    check_val("done_busy", busy, 0);

    // Cancel with total 35 and a coincident coin.
    quiet(); session_start = 1; step();
    coin(2'b10); coin(2'b01); coin(2'b00);
    quiet(); txn_cancel = 1; coin_valid = 1; coin_type = 2'b01; step();
    check_val("cxl_reject", coin_reject, 1);
    check_val("cxl_amount", refund_amount, 35);
    quiet();
    for (int i = 0; i < 5; i++) begin
      step();
      check_val("hold_amount", refund_amount, 35);
    end
    refund_ack = 1; step();
    check_val("ack_rvalid", refund_valid, 0);
    check_val("ack_busy", busy, 0);

    // Timeout exactly TMO edges after the accept edge.
    quiet(); session_start = 1; step();
    coin(2'b00);
    quiet();
    for (int k = 1; k <= TMO; k++) begin
      step();
      check_val("tmo_rvalid", refund_valid, (k == TMO) ? 1 : 0);
    end
    check_val("tmo_amount", refund_amount, 5);

    // Reset mid-refund discards the credit with no ack.
    reset = 1'b0; step();
    check_val("rst_ref_rvalid", refund_valid, 0);
    check_val("rst_ref_total", total_coins, 0);
    reset = 1'b1;

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      reset         = ($urandom_range(0, 199) != 0);
      session_start = ($urandom_range(0, 3) == 0);
      coin_valid    = ($urandom_range(0, 1) == 0);
      coin_type     = 2'($urandom_range(0, 3));
      txn_done      = ($urandom_range(0, 29) == 0);
      txn_cancel    = ($urandom_range(0, 24) == 0);
      refund_ack    = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
